// File: rtl/ahbl_pkg.sv
// ---------------------------------------------------------------------------
// ahbl_pkg
// Shared AHB-Lite encodings for the two-master / one-slave arbiter slice:
//   - HTRANS transfer-type encodings
//   - address/data-phase owner encoding (none, M1 = IFU, M2 = LSU)
//   - HSIZE encodings
//   - owner_of(): maps a master index (0/1) to its owner code
// ---------------------------------------------------------------------------
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M1   = 2'd1,
    OWN_M2   = 2'd2
  } owner_t;

  // Master index 0 is M1, index 1 is M2.
  function automatic owner_t owner_of(input int idx);
    return (idx == 0) ? OWN_M1 : OWN_M2;
  endfunction

endpackage

// File: rtl/ahbl_rsp_buf.sv
// ---------------------------------------------------------------------------
// ahbl_rsp_buf
// One master's response holding register. When the slave completes this
// master's data phase while the master is stalled on a new address, the read
// data is captured and replayed to the master until its stall is released.
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   cap           : capture HRDATA into the buffer and mark it pending
//   rel           : master sees ready this cycle; drop the pending flag
//   hrdata        : slave read data
//   rdata         : read data presented to the master
// ---------------------------------------------------------------------------
module ahbl_rsp_buf #(
  parameter int DW = 64
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          cap,
  input  logic          rel,
  input  logic [DW-1:0] hrdata,
  output logic [DW-1:0] rdata
);

  logic          pend_reg;
  logic [DW-1:0] data_reg;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_reg <= 1'b0;
      data_reg <= '0;
    end else begin
      // Release wins; cap and rel cannot both be high since cap needs the
      // master to be stalled.
      if (rel) begin
        pend_reg <= 1'b0;
      end else if (cap) begin
        pend_reg <= 1'b1;
        data_reg <= hrdata;
      end
    end
  end

  assign rdata = pend_reg ? data_reg : hrdata;

endmodule

// File: rtl/ahbl_rr_arbiter_2m1s.sv
// ---------------------------------------------------------------------------
// ahbl_rr_arbiter_2m1s
// Round-robin AHB-Lite arbiter sharing one slave port between M1 (EL2 IFU)
// and M2 (EL2 LSU). Address and data phase ownership are tracked separately;
// a losing master is stalled with its address held, and a read response that
// completes while its master is stalled is buffered for later delivery.
// Ports:
//   HCLK, HRESETn                 : clock, asynchronous active-low reset
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA_M1/_M2 : master request inputs
//   HREADY_M1/_M2, HRDATA_M1/_M2  : per-master ready and read data
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA : slave request outputs
//   HRDATA, HREADY                : slave response inputs
// Parameters:
//   AW, DW     : address / data width
//   BURST_LOCK : owner keeps the grant while it presents SEQ
// ---------------------------------------------------------------------------
module ahbl_rr_arbiter_2m1s
  import ahbl_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 64,
  parameter bit BURST_LOCK = 1'b1
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [AW-1:0] HADDR_M1,
  input  logic [1:0]    HTRANS_M1,
  input  logic          HWRITE_M1,
  input  logic [2:0]    HSIZE_M1,
  input  logic [DW-1:0] HWDATA_M1,
  input  logic [AW-1:0] HADDR_M2,
  input  logic [1:0]    HTRANS_M2,
  input  logic          HWRITE_M2,
  input  logic [2:0]    HSIZE_M2,
  input  logic [DW-1:0] HWDATA_M2,
  output logic          HREADY_M1,
  output logic [DW-1:0] HRDATA_M1,
  output logic          HREADY_M2,
  output logic [DW-1:0] HRDATA_M2,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [DW-1:0] HWDATA,
  input  logic [DW-1:0] HRDATA,
  input  logic          HREADY
);

  logic   hold_reg;
  owner_t sel_reg;
  owner_t dph_reg;
  owner_t last_reg;

  owner_t     sel_next;
  logic [1:0] htrans_last;
  logic [1:0] req;
  logic [1:0] mrdy;
  logic [1:0] cap;
  logic [1:0] htrans_m [2];
  logic [DW-1:0] rdata_m [2];

  assign htrans_m[0] = HTRANS_M1;
  assign htrans_m[1] = HTRANS_M2;

  // ---------------------------------------------------------------------
  // Address-phase selection
  // ---------------------------------------------------------------------
  always_comb begin
    sel_next    = OWN_NONE;
    htrans_last = (last_reg == OWN_M1) ? HTRANS_M1 : HTRANS_M2;
    if (hold_reg) begin
      // Slave has not accepted the current address; it must not change.
      sel_next = sel_reg;
    end else if (BURST_LOCK && (htrans_last == HTRANS_SEQ)) begin
      sel_next = last_reg;
    end else begin
      case (req)
        2'b01:   sel_next = OWN_M1;
        2'b10:   sel_next = OWN_M2;
        2'b11:   sel_next = (last_reg == OWN_M1) ? OWN_M2 : OWN_M1;
        default: sel_next = OWN_NONE;
      endcase
    end
  end

  always_comb begin
    HADDR  = '0;
    HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0;
    HSIZE  = HSIZE_BYTE;
    case (sel_next)
      OWN_M1: begin
        HADDR  = HADDR_M1;
        HTRANS = HTRANS_M1;
        HWRITE = HWRITE_M1;
        HSIZE  = HSIZE_M1;
      end
      OWN_M2: begin
        HADDR  = HADDR_M2;
        HTRANS = HTRANS_M2;
        HWRITE = HWRITE_M2;
        HSIZE  = HSIZE_M2;
      end
      default: ;
    endcase
  end

  // Write data follows the data-phase owner, not the address owner.
  always_comb begin
    HWDATA = '0;
    case (dph_reg)
      OWN_M1:  HWDATA = HWDATA_M1;
      OWN_M2:  HWDATA = HWDATA_M2;
      default: HWDATA = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Per-master ready and response buffering
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_mst
      localparam owner_t OWN_X = owner_of(gi);

      assign req[gi] = htrans_m[gi][1];

      // A requesting master is only released when it holds the address
      // phase; otherwise it just tracks its own data phase, if any.
      assign mrdy[gi] = req[gi]             ? ((sel_next == OWN_X) & HREADY) :
                        (dph_reg == OWN_X)  ? HREADY : 1'b1;

      // Slave finished this master's data phase but the master is stalled
      // on its next address: keep the response so it is not lost.
      assign cap[gi] = HREADY & (dph_reg == OWN_X) & ~mrdy[gi];

      ahbl_rsp_buf #(
        .DW (DW)
      ) u_rsp_buf (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .cap     (cap[gi]),
        .rel     (mrdy[gi]),
        .hrdata  (HRDATA),
        .rdata   (rdata_m[gi])
      );
    end
  endgenerate

  assign HREADY_M1 = mrdy[0];
  assign HREADY_M2 = mrdy[1];
  assign HRDATA_M1 = rdata_m[0];
  assign HRDATA_M2 = rdata_m[1];

  // ---------------------------------------------------------------------
  // Ownership state
  // ---------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_reg <= 1'b0;
      sel_reg  <= OWN_NONE;
      dph_reg  <= OWN_NONE;
      last_reg <= OWN_M2;   // M1 wins the first tie
    end else begin
      hold_reg <= (sel_next != OWN_NONE) & ~HREADY;
      sel_reg  <= sel_next;
      if (HREADY) begin
        dph_reg <= sel_next;
        if (sel_next != OWN_NONE) begin
          last_reg <= sel_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahbl_rr_arbiter_2m1s.sv
// ---------------------------------------------------------------------------
// tb_ahbl_rr_arbiter_2m1s
// Directed scoreboard bench. The stimulus process drives one cycle of master
// and slave inputs and queues the hand-computed expected outputs for that
// cycle; a monitor pops one entry per cycle on the falling edge and compares.
// A second instance with BURST_LOCK=0 shares the inputs so the non-locked
// grant order can be checked during the burst scenario.
// ---------------------------------------------------------------------------
module tb_ahbl_rr_arbiter_2m1s;

  localparam int AW = 32;
  localparam int DW = 64;

  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] S = 2'b11;

  localparam logic [7:0] K_TR = 8'h01;
  localparam logic [7:0] K_AD = 8'h02;
  localparam logic [7:0] K_R1 = 8'h04;
  localparam logic [7:0] K_R2 = 8'h08;
  localparam logic [7:0] K_D1 = 8'h10;
  localparam logic [7:0] K_D2 = 8'h20;
  localparam logic [7:0] K_WD = 8'h40;
  localparam logic [7:0] K_NL = 8'h80;

  localparam logic [DW-1:0] WD_M1 = 64'h0000_0000_0000_00A1;
  localparam logic [DW-1:0] WD_M2 = 64'h0000_0000_0000_00B2;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [AW-1:0] HADDR_M1, HADDR_M2;
  logic [1:0]    HTRANS_M1, HTRANS_M2;
  logic          HWRITE_M1, HWRITE_M2;
  logic [2:0]    HSIZE_M1, HSIZE_M2;
  logic [DW-1:0] HWDATA_M1, HWDATA_M2;
  logic          HREADY_M1, HREADY_M2;
  logic [DW-1:0] HRDATA_M1, HRDATA_M2;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [DW-1:0] HWDATA;
  logic [DW-1:0] HRDATA;
  logic          HREADY;

  logic          nl_HREADY_M1, nl_HREADY_M2;
  logic [DW-1:0] nl_HRDATA_M1, nl_HRDATA_M2;
  logic [AW-1:0] nl_HADDR;
  logic [1:0]    nl_HTRANS;
  logic          nl_HWRITE;
  logic [2:0]    nl_HSIZE;
  logic [DW-1:0] nl_HWDATA;

  always #5 HCLK = ~HCLK;

  ahbl_rr_arbiter_2m1s #(.AW(AW), .DW(DW), .BURST_LOCK(1'b1)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1),
    .HSIZE_M1(HSIZE_M1), .HWDATA_M1(HWDATA_M1),
    .HADDR_M2(HADDR_M2), .HTRANS_M2(HTRANS_M2), .HWRITE_M2(HWRITE_M2),
    .HSIZE_M2(HSIZE_M2), .HWDATA_M2(HWDATA_M2),
    .HREADY_M1(HREADY_M1), .HRDATA_M1(HRDATA_M1),
    .HREADY_M2(HREADY_M2), .HRDATA_M2(HRDATA_M2),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
  );

  ahbl_rr_arbiter_2m1s #(.AW(AW), .DW(DW), .BURST_LOCK(1'b0)) u_dut_nl (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1),
    .HSIZE_M1(HSIZE_M1), .HWDATA_M1(HWDATA_M1),
    .HADDR_M2(HADDR_M2), .HTRANS_M2(HTRANS_M2), .HWRITE_M2(HWRITE_M2),
    .HSIZE_M2(HSIZE_M2), .HWDATA_M2(HWDATA_M2),
    .HREADY_M1(nl_HREADY_M1), .HRDATA_M1(nl_HRDATA_M1),
    .HREADY_M2(nl_HREADY_M2), .HRDATA_M2(nl_HRDATA_M2),
    .HADDR(nl_HADDR), .HTRANS(nl_HTRANS), .HWRITE(nl_HWRITE), .HSIZE(nl_HSIZE),
    .HWDATA(nl_HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
  );

  typedef struct {
    string         name;
    logic [7:0]    chk;
    logic [1:0]    htrans;
    logic [AW-1:0] haddr;
    logic          rdy1;
    logic          rdy2;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] wd;
    logic [AW-1:0] nl_haddr;
  } exp_t;

  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_bad_entry;

  // One comparison; a mismatch prints a single FAIL line.
  task automatic cmp(input string nm, input string fld,
                     input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      n_bad_entry++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
    end
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge HCLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_bad_entry = 0;
      if (e.chk[0]) cmp(e.name, "HTRANS",    {62'd0, HTRANS},    {62'd0, e.htrans});
      if (e.chk[1]) cmp(e.name, "HADDR",     {32'd0, HADDR},     {32'd0, e.haddr});
      if (e.chk[2]) cmp(e.name, "HREADY_M1", {63'd0, HREADY_M1}, {63'd0, e.rdy1});
      if (e.chk[3]) cmp(e.name, "HREADY_M2", {63'd0, HREADY_M2}, {63'd0, e.rdy2});
      if (e.chk[4]) cmp(e.name, "HRDATA_M1", HRDATA_M1, e.rd1);
      if (e.chk[5]) cmp(e.name, "HRDATA_M2", HRDATA_M2, e.rd2);
      if (e.chk[6]) cmp(e.name, "HWDATA",    HWDATA,    e.wd);
      if (e.chk[7]) cmp(e.name, "nl_HADDR",  {32'd0, nl_HADDR}, {32'd0, e.nl_haddr});
      $display("[%0t] %-8s HTRANS=%b HADDR=0x%0h rdy1=%b rdy2=%b bad=%0d",
               $time, e.name, HTRANS, HADDR, HREADY_M1, HREADY_M2, n_bad_entry);
    end
  end

  // Drive one cycle of inputs and queue the expected outputs.
  task automatic cyc(input string nm, input logic rstn,
                     input logic [1:0] t1, input logic [AW-1:0] a1,
                     input logic [1:0] t2, input logic [AW-1:0] a2,
                     input logic rdy, input logic [DW-1:0] rdata,
                     input logic [7:0] chk,
                     input logic [1:0] e_tr, input logic [AW-1:0] e_ad,
                     input logic e_r1, input logic e_r2,
                     input logic [DW-1:0] e_d1, input logic [DW-1:0] e_d2,
                     input logic [DW-1:0] e_wd, input logic [AW-1:0] e_nl);
    exp_t e;
    HRESETn   = rstn;
    HTRANS_M1 = t1;
    HADDR_M1  = a1;
    HTRANS_M2 = t2;
    HADDR_M2  = a2;
    HREADY    = rdy;
    HRDATA    = rdata;
    e.name     = nm;
    e.chk      = chk;
    e.htrans   = e_tr;
    e.haddr    = e_ad;
    e.rdy1     = e_r1;
    e.rdy2     = e_r2;
    e.rd1      = e_d1;
    e.rd2      = e_d2;
    e.wd       = e_wd;
    e.nl_haddr = e_nl;
    exp_q.push_back(e);
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    HRESETn   = 1'b0;
    HTRANS_M1 = I;  HADDR_M1 = '0; HWRITE_M1 = 1'b0; HSIZE_M1 = 3'd3; HWDATA_M1 = WD_M1;
    HTRANS_M2 = I;  HADDR_M2 = '0; HWRITE_M2 = 1'b1; HSIZE_M2 = 3'd2; HWDATA_M2 = WD_M2;
    HREADY    = 1'b1;
    HRDATA    = '0;
    @(posedge HCLK);
    #1;

    // Reset state
    cyc("rst", 0, I, 0, I, 0, 1, 64'hF00D, K_TR|K_AD|K_R1|K_R2|K_D1|K_D2|K_WD,
        I, 0, 1, 1, 64'hF00D, 64'hF00D, 0, 0);

    // Single master read, zero added latency
    cyc("s1_addr", 1, N, 'h100, I, 0, 1, 0, K_TR|K_AD|K_R1|K_R2|K_WD,
        N, 'h100, 1, 1, 0, 0, 0, 0);
    cyc("s1_data", 1, I, 0, I, 0, 1, 64'hA5A5, K_TR|K_R1|K_R2|K_D1|K_WD,
        I, 0, 1, 1, 64'hA5A5, 0, WD_M1, 0);

    // Collision straight after reset: M1 first, then M2
    cyc("s2_rst", 0, I, 0, I, 0, 1, 0, K_TR|K_R1|K_R2,
        I, 0, 1, 1, 0, 0, 0, 0);
    cyc("s2_coll", 1, N, 'h200, N, 'h300, 1, 0, K_TR|K_AD|K_R1|K_R2,
        N, 'h200, 1, 0, 0, 0, 0, 0);
    cyc("s2_m2", 1, I, 0, N, 'h300, 1, 64'h1111, K_AD|K_R1|K_R2|K_D1|K_WD,
        N, 'h300, 1, 1, 64'h1111, 0, WD_M1, 0);
    cyc("s2_m2d", 1, I, 0, I, 0, 1, 64'h2222, K_TR|K_R2|K_D2|K_WD,
        I, 0, 1, 1, 0, 64'h2222, WD_M2, 0);

    // Buffered response: M1 loses while its data phase completes
    cyc("s3_a", 1, N, 'h400, I, 0, 1, 0, K_AD|K_R1,
        N, 'h400, 1, 1, 0, 0, 0, 0);
    cyc("s3_cap", 1, N, 'h408, N, 'h500, 1, 64'h1234, K_AD|K_R1|K_R2,
        N, 'h500, 0, 1, 0, 0, 0, 0);
    cyc("s3_rel", 1, N, 'h408, I, 0, 1, 64'h5678, K_AD|K_R1|K_R2|K_D1|K_D2,
        N, 'h408, 1, 1, 64'h1234, 64'h5678, 0, 0);
    cyc("s3_d", 1, I, 0, I, 0, 1, 64'h9ABC, K_R1|K_D1,
        I, 0, 1, 1, 64'h9ABC, 0, 0, 0);

    // Slave wait states: M2 address held, M1 request must wait
    cyc("s4_w1", 1, I, 0, N, 'h600, 0, 0, K_TR|K_AD|K_R1|K_R2,
        N, 'h600, 1, 0, 0, 0, 0, 0);
    cyc("s4_w2", 1, N, 'h700, N, 'h600, 0, 0, K_TR|K_AD|K_R1|K_R2,
        N, 'h600, 0, 0, 0, 0, 0, 0);
    cyc("s4_w3", 1, N, 'h700, N, 'h600, 0, 0, K_TR|K_AD|K_R1|K_R2,
        N, 'h600, 0, 0, 0, 0, 0, 0);
    cyc("s4_go", 1, N, 'h700, N, 'h600, 1, 0, K_AD|K_R1|K_R2,
        N, 'h600, 0, 1, 0, 0, 0, 0);
    cyc("s4_m1", 1, N, 'h700, I, 0, 1, 64'hCAFE, K_AD|K_R1|K_R2|K_D2,
        N, 'h700, 1, 1, 0, 64'hCAFE, 0, 0);
    cyc("s4_d", 1, I, 0, I, 0, 1, 64'hBEEF, K_R1|K_D1,
        I, 0, 1, 1, 64'hBEEF, 0, 0, 0);

    // Burst lock: M2 keeps the grant through its SEQ beats
    cyc("s5_nseq", 1, N, 'h900, N, 'h800, 1, 0, K_AD|K_R1|K_R2|K_NL,
        N, 'h800, 0, 1, 0, 0, 0, 'h800);
    cyc("s5_seq1", 1, N, 'h900, S, 'h808, 1, 0, K_AD|K_R1|K_R2|K_NL,
        S, 'h808, 0, 1, 0, 0, 0, 'h900);
    cyc("s5_seq2", 1, N, 'h900, S, 'h810, 1, 0, K_TR|K_AD|K_R1,
        S, 'h810, 0, 1, 0, 0, 0, 0);
    cyc("s5_seq3", 1, N, 'h900, S, 'h818, 1, 0, K_TR|K_AD|K_R1,
        S, 'h818, 0, 1, 0, 0, 0, 0);
    cyc("s5_m1", 1, N, 'h900, I, 0, 1, 64'hD0D0, K_AD|K_R1|K_R2|K_D2,
        N, 'h900, 1, 1, 0, 64'hD0D0, 0, 0);
    cyc("s5_d", 1, I, 0, I, 0, 1, 64'hE0E0, K_R1|K_D1,
        I, 0, 1, 1, 64'hE0E0, 0, 0, 0);

    // Reset mid-operation with an M2 response buffered
    cyc("s6_a", 1, I, 0, N, 'hA00, 1, 0, K_AD|K_R2,
        N, 'hA00, 1, 1, 0, 0, 0, 0);
    cyc("s6_cap", 1, N, 'hB00, N, 'hA08, 1, 64'h7777, K_AD|K_R1|K_R2,
        N, 'hB00, 1, 0, 0, 0, 0, 0);
    cyc("s6_rst", 0, I, 0, I, 0, 1, 64'h3333, K_TR|K_AD|K_R1|K_R2|K_D1|K_D2|K_WD,
        I, 0, 1, 1, 64'h3333, 64'h3333, 0, 0);
    cyc("s6_post", 1, I, 0, N, 'hC80, 1, 64'h4444, K_TR|K_AD|K_R2|K_D2,
        N, 'hC80, 1, 1, 0, 64'h4444, 0, 0);
    cyc("s6_d", 1, I, 0, I, 0, 1, 64'h5555, K_R2|K_D2|K_WD,
        I, 0, 1, 1, 0, 64'h5555, WD_M2, 0);

    @(negedge HCLK);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
